// File: rtl/onchip_memory_copy_master.sv
// Avalon-MM copy master: moves a block of words from a source word range to a
// destination word range of the on-chip memory, one transaction at a time.
module onchip_memory_copy_master #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   src_base,
  input  logic [ADDR_WIDTH-1:0]   dst_base,
  input  logic [LEN_WIDTH-1:0]    length,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH-1:0]   master_address,
  output logic                    master_read,
  output logic                    master_write,
  output logic [DATA_WIDTH/8-1:0] master_byteenable,
  output logic [DATA_WIDTH-1:0]   master_writedata,
  input  logic                    master_waitrequest,
  input  logic [DATA_WIDTH-1:0]   master_readdata,
  input  logic                    master_readdatavalid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT_DATA,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  src_ptr;
  logic [ADDR_WIDTH-1:0]  dst_ptr;
  logic [LEN_WIDTH-1:0]   len_r;
  logic [LEN_WIDTH-1:0]   cnt;
  logic [LEN_WIDTH-1:0]   cnt_next;
  logic [ADDR_WIDTH-1:0]  src_next;
  logic [ADDR_WIDTH-1:0]  dst_next;

  // Post-increment values of the word counter and both pointers (pointers wrap).
  always_comb begin
    cnt_next = cnt + 1'b1;
    src_next = src_ptr + 1'b1;
    dst_next = dst_ptr + 1'b1;
  end

  // Copy sequencer; bus outputs are registered and set for the state being entered.
  // master_writedata doubles as the captured read-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      src_ptr           <= '0;
      dst_ptr           <= '0;
      len_r             <= '0;
      cnt               <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      master_address    <= '0;
      master_read       <= 1'b0;
      master_write      <= 1'b0;
      master_byteenable <= '0;
      master_writedata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            src_ptr <= src_base;
            dst_ptr <= dst_base;
            len_r   <= length;
            cnt     <= '0;
            if (length != '0) begin
              state             <= S_READ;
              busy              <= 1'b1;
              master_read       <= 1'b1;
              master_address    <= src_base;
              master_byteenable <= '1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_READ: begin
          if (!master_waitrequest) begin
            state             <= S_WAIT_DATA;
            master_read       <= 1'b0;
            master_byteenable <= '0;
          end
        end

        S_WAIT_DATA: begin
          if (master_readdatavalid) begin
            state             <= S_WRITE;
            master_write      <= 1'b1;
            master_address    <= dst_ptr;
            master_writedata  <= master_readdata;
            master_byteenable <= '1;
          end
        end

        S_WRITE: begin
          if (!master_waitrequest) begin
            master_write <= 1'b0;
            src_ptr      <= src_next;
            dst_ptr      <= dst_next;
            cnt          <= cnt_next;
            if (cnt_next == len_r) begin
              state             <= S_DONE;
              busy              <= 1'b0;
              done              <= 1'b1;
              master_byteenable <= '0;
            end else begin
              state          <= S_READ;
              master_read    <= 1'b1;
              master_address <= src_next;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end

        default: begin
          state             <= S_IDLE;
          busy              <= 1'b0;
          done              <= 1'b0;
          master_read       <= 1'b0;
          master_write      <= 1'b0;
          master_byteenable <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_memory_copy_master.sv
// Directed testbench for onchip_memory_copy_master with a behavioural
// Avalon-MM memory slave (programmable waitrequest and readdatavalid delay).
module tb_onchip_memory_copy_master;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] dst_base = '0;
  logic [LW-1:0] length = '0;
  logic          busy, done;
  logic [AW-1:0] master_address;
  logic          master_read, master_write;
  logic [DW/8-1:0] master_byteenable;
  logic [DW-1:0] master_writedata;
  logic          waitreq = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          rdv = 1'b0;

  onchip_memory_copy_master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk                 (clk),
    .reset               (rst),
    .start               (start),
    .src_base            (src_base),
    .dst_base            (dst_base),
    .length              (length),
    .busy                (busy),
    .done                (done),
    .master_address      (master_address),
    .master_read         (master_read),
    .master_write        (master_write),
    .master_byteenable   (master_byteenable),
    .master_writedata    (master_writedata),
    .master_waitrequest  (waitreq),
    .master_readdata     (rdata),
    .master_readdatavalid(rdv)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // slave model state and statistics
  logic [DW-1:0] mem [0:32767];
  int            mode = 0;     // 0: no stall, 1: random stall + 1..3 rdv delay, 2: stall each write 2 cycles
  int            reads, writes, done_cnt, stall_err, be_err, rw_both;
  int            rd_cnt = 0;
  int            wstall = 0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_log[$];
  logic          prev_stalled = 1'b0;
  logic [AW+DW+1:0] prev_sig = '0;

  // Memory slave: decides waitrequest for the coming edge and commits accepted transfers.
  always @(negedge clk) begin
    if (rst) begin
      rdv = 1'b0;
      waitreq = 1'b0;
      rd_cnt = 0;
      wstall = 0;
      prev_stalled = 1'b0;
    end else begin
      if (prev_stalled && ({master_read, master_write, master_address, master_writedata} !== prev_sig))
        stall_err++;
      if (master_read && master_write) rw_both++;
      if ((master_read || master_write) ? (master_byteenable !== 4'hF) : (master_byteenable !== 4'h0))
        be_err++;
      if (done === 1'b1) done_cnt++;
      rdv = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          rdv = 1'b1;
          rdata = mem[rd_addr];
        end
      end
      case (mode)
        1: waitreq = 1'($urandom_range(0, 1));
        2: waitreq = master_write && (wstall < 2);
        default: waitreq = 1'b0;
      endcase
      if (master_write && waitreq) wstall++;
      else if (master_write) wstall = 0;
      if (master_read && !waitreq) begin
        reads++;
        rd_log.push_back(master_address);
        rd_addr = master_address;
        rd_cnt = (mode == 1) ? int'($urandom_range(1, 3)) : 1;
      end
      if (master_write && !waitreq) begin
        writes++;
        wr_log.push_back(master_address);
        mem[master_address] = master_writedata;
      end
      prev_sig = {master_read, master_write, master_address, master_writedata};
      prev_stalled = (master_read || master_write) && waitreq;
    end
  end

  task automatic clear_stats(input int m);
    @(posedge clk);
    #1;
    mode = m;
    reads = 0; writes = 0; done_cnt = 0;
    stall_err = 0; be_err = 0; rw_both = 0;
    rd_log.delete();
    wr_log.delete();
  endtask

  task automatic test_reset();
    int anynz;
    anynz = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, master_read, master_write} !== 4'b0) begin
      bad++;
      $display("FAIL reset_held_strobes: got %b want 0000", {busy, done, master_read, master_write});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_stats(0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if ({busy, done, master_read, master_write} !== 4'b0 || master_address !== '0 ||
          master_byteenable !== '0 || master_writedata !== '0)
        anynz++;
    end
    total++;
    if (anynz !== 0) begin
      bad++;
      $display("FAIL reset_idle_outputs: nonzero cycles got %0d want 0", anynz);
    end
    total++;
    if (master_address !== '0 || master_writedata !== '0 || master_byteenable !== '0) begin
      bad++;
      $display("FAIL reset_bus_values: addr %h wd %h be %h want 0", master_address, master_writedata, master_byteenable);
    end
    total++;
    if (reads + writes !== 0) begin
      bad++;
      $display("FAIL reset_no_strobes: got %0d transfers want 0", reads + writes);
    end
  endtask

  task automatic test_basic();
    int bfirst, blast, bn, done_at, dn;
    bfirst = -1; blast = -1; bn = 0; done_at = -1; dn = 0;
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'hA000_0000 + 32'(i);
    clear_stats(0);
    @(negedge clk);
    src_base = 15'h0010; dst_base = 15'h0100; length = 16'd4; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) begin
        if (bfirst < 0) bfirst = c;
        blast = c;
        bn++;
      end
      if (done) begin
        done_at = c;
        dn++;
      end
    end
    total++;
    if (bfirst !== 1 || blast !== 12 || bn !== 12) begin
      bad++;
      $display("FAIL basic_busy: got first %0d last %0d n %0d want 1 12 12", bfirst, blast, bn);
    end
    total++;
    if (done_at !== 13 || dn !== 1) begin
      bad++;
      $display("FAIL basic_done: got cycle %0d count %0d want 13 1", done_at, dn);
    end
    total++;
    if (reads !== 4 || writes !== 4) begin
      bad++;
      $display("FAIL basic_counts: got reads %0d writes %0d want 4 4", reads, writes);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[256 + i] !== 32'hA000_0000 + 32'(i)) begin
        bad++;
        $display("FAIL basic_data[%0d]: got %h want %h", i, mem[256 + i], 32'hA000_0000 + 32'(i));
      end
    end
    total++;
    if (be_err !== 0 || rw_both !== 0) begin
      bad++;
      $display("FAIL basic_strobes: got be_err %0d rw_both %0d want 0 0", be_err, rw_both);
    end
  endtask

  task automatic test_zero_len();
    int bn, done_at, dn;
    bn = 0; done_at = -1; dn = 0;
    clear_stats(0);
    @(negedge clk);
    src_base = 15'h0020; dst_base = 15'h0030; length = 16'd0; start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bn++;
      if (done) begin
        done_at = c;
        dn++;
      end
    end
    total++;
    if (done_at !== 1 || dn !== 1) begin
      bad++;
      $display("FAIL zero_done: got cycle %0d count %0d want 1 1", done_at, dn);
    end
    total++;
    if (bn !== 0 || reads + writes !== 0) begin
      bad++;
      $display("FAIL zero_quiet: got busy %0d transfers %0d want 0 0", bn, reads + writes);
    end
  endtask

  task automatic test_random_stall();
    int done_at;
    done_at = -1;
    for (int i = 0; i < 8; i++) mem[16'h0200 + i] = 32'h5A5A_0000 + 32'(i * 3);
    clear_stats(1);
    @(negedge clk);
    src_base = 15'h0200; dst_base = 15'h0300; length = 16'd8; start = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done && done_at < 0) done_at = c;
      if (done_at > 0 && c > done_at + 5) break;
    end
    total++;
    if (done_at < 0) begin
      bad++;
      $display("FAIL rand_timeout: done never seen within 600 cycles, want done");
    end
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL rand_done_once: got %0d want 1", done_cnt);
    end
    total++;
    if (stall_err !== 0) begin
      bad++;
      $display("FAIL rand_stall_stable: got %0d changes want 0", stall_err);
    end
    total++;
    if (writes !== 8 || rw_both !== 0 || be_err !== 0) begin
      bad++;
      $display("FAIL rand_strobes: got writes %0d rw_both %0d be_err %0d want 8 0 0", writes, rw_both, be_err);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (mem[16'h0300 + i] !== 32'h5A5A_0000 + 32'(i * 3)) begin
        bad++;
        $display("FAIL rand_data[%0d]: got %h want %h", i, mem[16'h0300 + i], 32'h5A5A_0000 + 32'(i * 3));
      end
    end
    mode = 0;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_rd [4];
    logic [DW-1:0] exp_d [4];
    exp_rd[0] = 15'h7FFE; exp_rd[1] = 15'h7FFF; exp_rd[2] = 15'h0000; exp_rd[3] = 15'h0001;
    // destination overlaps the wrapped source: words 2,3 re-read freshly written data
    exp_d[0] = 32'h1111_1111; exp_d[1] = 32'h2222_2222; exp_d[2] = 32'h1111_1111; exp_d[3] = 32'h2222_2222;
    mem[15'h7FFE] = 32'h1111_1111; mem[15'h7FFF] = 32'h2222_2222;
    mem[0] = 32'h3333_3333; mem[1] = 32'h4444_4444;
    clear_stats(0);
    @(negedge clk);
    src_base = 15'h7FFE; dst_base = 15'h0000; length = 16'd4; start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    total++;
    if (rd_log.size() !== 4 || wr_log.size() !== 4) begin
      bad++;
      $display("FAIL wrap_counts: got reads %0d writes %0d want 4 4", rd_log.size(), wr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (rd_log[i] !== exp_rd[i] || wr_log[i] !== 15'(i)) begin
          bad++;
          $display("FAIL wrap_addr[%0d]: got rd %h wr %h want rd %h wr %h", i, rd_log[i], wr_log[i], exp_rd[i], 15'(i));
        end
        total++;
        if (mem[i] !== exp_d[i]) begin
          bad++;
          $display("FAIL wrap_data[%0d]: got %h want %h", i, mem[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_copy();
    int wcount, done_at, dn;
    wcount = 0; done_at = -1; dn = 0;
    for (int i = 0; i < 6; i++) mem[16'h0400 + i] = 32'hBEEF_0000 + 32'(i);
    clear_stats(2);
    @(negedge clk);
    src_base = 15'h0400; dst_base = 15'h0500; length = 16'd6; start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (master_write) wcount++;
      if (wcount == 4) break;   // first stall cycle of the second write
    end
    total++;
    if (wcount !== 4) begin
      bad++;
      $display("FAIL rstmid_reach: got %0d write cycles want 4", wcount);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy, done, master_read, master_write} !== 4'b0) begin
      bad++;
      $display("FAIL rstmid_strobes: got %b want 0000", {busy, done, master_read, master_write});
    end
    total++;
    if (master_address !== '0 || master_byteenable !== '0 || master_writedata !== '0) begin
      bad++;
      $display("FAIL rstmid_bus: got addr %h be %h wd %h want 0", master_address, master_byteenable, master_writedata);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    mode = 0;
    repeat (5) @(negedge clk);
    total++;
    if (done_cnt !== 0 || writes !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_abandon: got done %0d writes %0d busy %b want 0 1 0", done_cnt, writes, busy);
    end

    // fresh copy; extra starts while busy and in the DONE cycle must be ignored
    for (int i = 0; i < 3; i++) mem[16'h0600 + i] = 32'hC0DE_0000 + 32'(i);
    clear_stats(0);
    @(negedge clk);
    src_base = 15'h0600; dst_base = 15'h0700; length = 16'd3; start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_at = c;
        dn++;
      end
      if (c == 3 || c == 10) begin
        src_base = 15'h0050; length = 16'd9; start = 1'b1;
      end
    end
    total++;
    if (done_at !== 10 || dn !== 1) begin
      bad++;
      $display("FAIL fresh_done: got cycle %0d count %0d want 10 1", done_at, dn);
    end
    total++;
    if (reads !== 3 || writes !== 3 || rd_log.size() !== 3 || rd_log[0] !== 15'h0600 || rd_log[2] !== 15'h0602) begin
      bad++;
      $display("FAIL fresh_reads: got reads %0d writes %0d want 3 3 from 0600", reads, writes);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem[16'h0700 + i] !== 32'hC0DE_0000 + 32'(i)) begin
        bad++;
        $display("FAIL fresh_data[%0d]: got %h want %h", i, mem[16'h0700 + i], 32'hC0DE_0000 + 32'(i));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_zero_len();
    test_random_stall();
    test_wrap();
    test_reset_mid_copy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
